// File: rtl/spi_sub_aes_port_if.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_sub_aes_port_if : key/block/result bus between SPI port and AES core
// Revision: 1.0
// ------------------------------------------------------------------
interface spi_sub_aes_port_if;
  logic         key_load;
  logic [1:0]   key_size;
  logic [255:0] key;
  logic         blk_start;
  logic [127:0] blk_in;
  logic         blk_done;
  logic [127:0] blk_out;

  modport master (
    output key_load, key_size, key, blk_start, blk_in,
    input  blk_done, blk_out
  );

  modport slave (
    input  key_load, key_size, key, blk_start, blk_in,
    output blk_done, blk_out
  );
endinterface
`default_nettype wire

// File: rtl/spi_sub_aes_port.sv
`default_nettype none
// ------------------------------------------------------------------
// spi_sub_aes_port : oversampled SPI subordinate deframing key/block/result
// Revision: 1.0
// ------------------------------------------------------------------
module spi_sub_aes_port #(
  parameter int SYNC_STAGES    = 2,
  parameter int KEY_FRAME_BITS = 258,
  parameter int BLK_BITS       = 128
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            cs_n,
  input  wire logic            sclk,
  input  wire logic            sdi,
  output logic                 sdo,
  spi_sub_aes_port_if.master   aes,
  output logic                 frame_err,
  output logic [2:0]           state_o
);

  localparam logic [8:0] KEY_LEN = 9'(KEY_FRAME_BITS);
  localparam logic [8:0] BLK_LEN = 9'(BLK_BITS);
  localparam logic [8:0] CNT_MAX = 9'd511;

  typedef enum logic [2:0] {
    WAIT_KEY = 3'd0,
    WAIT_BLK = 3'd1,
    BUSY     = 3'd2,
    RESULT   = 3'd3,
    READ     = 3'd4
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0]    sclk_sync, cs_sync, sdi_sync;
  logic                      sclk_q, cs_q;
  logic                      sclk_s, cs_s, sdi_s;
  logic                      sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                      in_frame;
  logic                      frame_start, frame_end;
  logic [8:0]                bit_cnt;
  logic [KEY_FRAME_BITS-1:0] shreg;
  logic [1:0]                rx_code;
  logic                      key_ok;
  logic [127:0]              res_shift, res_hold;
  logic                      do_key, do_blk, do_err, do_cap, do_reload;

  // Synchronisers reset low: a cs_n fall can only follow an observed high,
  // so a frame interrupted by rst is ignored until cs_n returns high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      sdi_sync  <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      cs_q      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_s & cs_q;
  assign cs_rise   = cs_s & ~cs_q;

  assign frame_start = cs_fall;
  assign frame_end   = cs_rise & in_frame;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (frame_start) begin
      in_frame <= 1'b1;
      bit_cnt  <= '0;
    end else if (frame_end) begin
      in_frame <= 1'b0;
    end else if (in_frame && sclk_rise) begin
      shreg <= {shreg[KEY_FRAME_BITS-2:0], sdi_s};
      if (bit_cnt != CNT_MAX) begin
        bit_cnt <= bit_cnt + 9'd1;
      end
    end
  end

  assign rx_code = shreg[KEY_FRAME_BITS-1 -: 2];
  assign key_ok  = (bit_cnt == KEY_LEN) && (rx_code != 2'b11);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_KEY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    do_key    = 1'b0;
    do_blk    = 1'b0;
    do_err    = 1'b0;
    do_cap    = 1'b0;
    do_reload = 1'b0;
    case (state)
      WAIT_KEY: begin
        if (frame_end) begin
          if (key_ok) begin
            do_key  = 1'b1;
            state_n = WAIT_BLK;
          end else begin
            do_err = 1'b1;
          end
        end
      end
      WAIT_BLK: begin
        if (frame_end) begin
          if (bit_cnt == BLK_LEN) begin
            do_blk  = 1'b1;
            state_n = BUSY;
          end else if (key_ok) begin
            do_key = 1'b1;
          end else begin
            do_err = 1'b1;
          end
        end
      end
      BUSY: begin
        // Any frame here is premature; a coincident blk_done still wins the state.
        if (aes.blk_done) begin
          do_cap  = 1'b1;
          state_n = RESULT;
        end
        if (frame_end) begin
          do_err = 1'b1;
        end
      end
      RESULT: begin
        if (frame_start) begin
          state_n = READ;
        end
      end
      READ: begin
        if (frame_end) begin
          if (bit_cnt == BLK_LEN) begin
            state_n = WAIT_BLK;
          end else begin
            do_err    = 1'b1;
            do_reload = 1'b1;
            state_n   = RESULT;
          end
        end
      end
      default: state_n = WAIT_KEY;
    endcase
  end

  // Held copy lets a failed read be retried from bit 127.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_shift <= '0;
      res_hold  <= '0;
    end else if (do_cap) begin
      res_shift <= aes.blk_out;
      res_hold  <= aes.blk_out;
    end else if (do_reload) begin
      res_shift <= res_hold;
    end else if (state == READ && sclk_fall) begin
      res_shift <= {res_shift[126:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aes.key_load  <= 1'b0;
      aes.blk_start <= 1'b0;
      frame_err     <= 1'b0;
      aes.key       <= '0;
      aes.key_size  <= '0;
      aes.blk_in    <= '0;
    end else begin
      aes.key_load  <= do_key;
      aes.blk_start <= do_blk;
      frame_err     <= do_err;
      if (do_key) begin
        aes.key_size <= rx_code;
        aes.key      <= shreg[255:0];
      end
      if (do_blk) begin
        aes.blk_in <= shreg[BLK_BITS-1:0];
      end
    end
  end

  assign sdo     = (state == READ) && !cs_s ? res_shift[127] : 1'b0;
  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_spi_sub_aes_port.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_spi_sub_aes_port : directed SPI frames with a strobe scoreboard
// Revision: 1.0
// ------------------------------------------------------------------
module tb_spi_sub_aes_port;
  localparam int H = 5;

  logic clk = 1'b0, rst = 1'b1, cs_n = 1'b1, sclk = 1'b0, sdi = 1'b0;
  logic sdo, frame_err;
  logic [2:0] state_o;

  spi_sub_aes_port_if bus();

  spi_sub_aes_port #(.SYNC_STAGES(2), .KEY_FRAME_BITS(258), .BLK_BITS(128)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .sclk(sclk), .sdi(sdi), .sdo(sdo),
    .aes(bus), .frame_err(frame_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int core_delay = 70;

  typedef struct {
    int           kind;   // 0 key_load, 1 blk_start, 2 frame_err
    logic [1:0]   ks;
    logic [255:0] key;
    logic [127:0] blk;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  function automatic void exp_push(input int kind, input logic [1:0] ks,
                                   input logic [255:0] k, input logic [127:0] b);
    ev_t e;
    e.kind = kind; e.ks = ks; e.key = k; e.blk = b;
    exp_q.push_back(e);
  endfunction

  function automatic logic [127:0] core_model(input logic [127:0] b);
    if (b == 128'h00112233445566778899aabbccddeeff)
      return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    return b ^ 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
  endfunction

  // Scoreboard monitor
  initial begin
    ev_t e;
    int k;
    forever begin
      @(negedge clk);
      if (bus.key_load || bus.blk_start || frame_err) begin
        k = bus.key_load ? 0 : (bus.blk_start ? 1 : 2);
        if (bus.key_load && bus.blk_start) check("strobe_overlap", 1, 0);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_strobe: got kind %0d required none", k);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", k, e.kind);
          if (e.kind == 0) begin
            check("key_size", bus.key_size, e.ks);
            check("key", bus.key, e.key);
          end else if (e.kind == 1) begin
            check("blk_in", bus.blk_in, e.blk);
          end
        end
      end
    end
  end

  // Model AES core
  initial begin
    logic [127:0] b;
    bus.blk_done = 1'b0;
    bus.blk_out  = '0;
    forever begin
      @(negedge clk);
      if (bus.blk_start) begin
        b = bus.blk_in;
        repeat (core_delay) @(posedge clk);
        #1 bus.blk_done = 1'b1; bus.blk_out = core_model(b);
        @(posedge clk);
        #1 bus.blk_done = 1'b0;
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sdo"}, sdo, 0);
    check({tag, "_key_load"}, bus.key_load, 0);
    check({tag, "_blk_start"}, bus.blk_start, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_key"}, bus.key, 0);
    check({tag, "_key_size"}, bus.key_size, 0);
    check({tag, "_blk_in"}, bus.blk_in, 0);
    check({tag, "_state"}, state_o, 0);
  endtask

  // Mode-0 main: sdi set while sclk low, sdo sampled just before each rise.
  task automatic spi_frame(input logic [257:0] data, input int nbits, input int rst_at,
                           output logic [127:0] rd);
    rd = '0;
    cs_n = 1'b0;
    cyc(H);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (nbits - 1 - i == rst_at) begin
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check_reset_outputs("midframe_rst");
      end
      sdi = data[i];
      cyc(H);
      rd = {rd[126:0], sdo};
      sclk = 1'b1;
      cyc(H);
      sclk = 1'b0;
    end
    cyc(H);
    cs_n = 1'b1;
    sdi  = 1'b0;
    cyc(4 * H);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (state_o == s) break;
    end
    check(name, state_o, s);
  endtask

  localparam logic [255:0] K128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [255:0] K192 = {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] B1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B2   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] B3   = 128'h13579bdf_2468ace0_fedcba98_76543210;

  initial begin
    logic [127:0] rd;
    logic [127:0] exp_res;

    cyc(5);
    rst = 1'b0;
    cyc(2);
    check_reset_outputs("reset");

    exp_push(2, 0, 0, 0);
    spi_frame({2'b11, K256}, 258, -1, rd);
    check("code11_state_wait_key", state_o, 0);

    exp_push(0, 2'b00, K128, 0);
    spi_frame({2'b00, K128}, 258, -1, rd);
    check("key128_state", state_o, 1);

    exp_push(1, 0, 0, B1);
    spi_frame({130'h0, B1}, 128, -1, rd);
    check("blk1_state_busy", state_o, 2);
    wait_state(3, "blk1_wait_result");
    spi_frame('0, 128, -1, rd);
    check("aes128_read", rd, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("read_done_state", state_o, 1);

    exp_push(0, 2'b01, K192, 0);
    spi_frame({2'b01, K192}, 258, -1, rd);
    exp_push(0, 2'b10, K256, 0);
    spi_frame({2'b10, K256}, 258, -1, rd);
    check("key256_state", state_o, 1);
    exp_push(2, 0, 0, 0);
    spi_frame({2'b11, K192}, 258, -1, rd);
    check("code11_wait_blk_state", state_o, 1);

    exp_push(2, 0, 0, 0);
    spi_frame({130'h0, B2}, 100, -1, rd);
    check("short_state", state_o, 1);

    core_delay = 3000;
    exp_push(1, 0, 0, B2);
    spi_frame({130'h0, B2}, 128, -1, rd);
    check("blk2_state_busy", state_o, 2);
    exp_push(2, 0, 0, 0);
    spi_frame('0, 128, -1, rd);
    check("busy_read_sdo_zero", rd, 0);
    check("busy_read_state", state_o, 2);
    wait_state(3, "blk2_wait_result");
    exp_res = core_model(B2);
    spi_frame('0, 128, -1, rd);
    check("blk2_read", rd, exp_res);
    check("blk2_read_state", state_o, 1);

    core_delay = 70;
    exp_push(1, 0, 0, B3);
    spi_frame({130'h0, B3}, 128, -1, rd);
    wait_state(3, "blk3_wait_result");
    exp_res = core_model(B3);
    exp_push(2, 0, 0, 0);
    spi_frame('0, 64, -1, rd);
    check("abort_read_first_half", rd[63:0], exp_res[127:64]);
    check("abort_state_result", state_o, 3);
    spi_frame('0, 128, -1, rd);
    check("retry_read", rd, exp_res);
    check("retry_state", state_o, 1);

    spi_frame({2'b10, K256}, 258, 40, rd);
    check("after_rst_state", state_o, 0);
    check("after_rst_no_strobes", exp_q.size(), 0);
    exp_push(0, 2'b00, K128, 0);
    spi_frame({2'b00, K128}, 258, -1, rd);
    check("after_rst_key_state", state_o, 1);

    cyc(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
